pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage. It holds the current instruction address and selects the next address each cycle from five sources: sequential step, branch, jump/call, return-address stack (RAS) pop, or exception vector. It also supports pipeline stalls. It sits between the branch/jump resolution logic and the instruction memory address input.

---
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program-counter sequencer. Selects the next
//               instruction address each cycle from exception vector, stall
//               hold, return-address-stack pop, jump/call, branch or the
//               sequential step, and maintains a circular return-address
//               stack with a sticky underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             exception_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             return_i,
  output logic [WIDTH-1:0] pc_result_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_underflow_o
);

  // Pointer addresses one of RAS_DEPTH slots; count needs one extra bit so
  // that it can represent RAS_DEPTH itself.
  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // STEP is a power of two, so STEP-1 covers exactly the low log2(STEP) bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  // Winning next-PC source for the current cycle.
  typedef enum logic [2:0] {
    SRC_SEQ       = 3'd0,
    SRC_BRANCH    = 3'd1,
    SRC_JUMP      = 3'd2,
    SRC_RET       = 3'd3,
    SRC_RET_EMPTY = 3'd4,
    SRC_HOLD      = 3'd5,
    SRC_EXC       = 3'd6
  } src_e;

  src_e             src_sel;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unf_q;
  logic             unf_d;

  // Return-address storage; contents are meaningless while count is zero.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_next;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             push_en;

  // ptr_q is the next slot to write, so the most recent entry sits one below.
  assign pc_next   = pc_q + STEP_W;
  assign top_idx   = ptr_q - PTR_W'(1);
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);

  // Resolve the request priority into a single winning source.
  always_comb begin
    src_sel = SRC_SEQ;
    if (exception_i) begin
      src_sel = SRC_EXC;
    end else if (stall_i) begin
      src_sel = SRC_HOLD;
    end else if (return_i) begin
      src_sel = ras_empty ? SRC_RET_EMPTY : SRC_RET;
    end else if (jump_i) begin
      src_sel = SRC_JUMP;
    end else if (branch_taken_i) begin
      src_sel = SRC_BRANCH;
    end
  end

  // Next PC, stack pointer/count and underflow flag from the winning source.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (src_sel)
      SRC_EXC: begin
        // Stack is left untouched so it survives the exception.
        pc_d = EXC_VECTOR & ALIGN_MASK;
      end
      SRC_HOLD: begin
        pc_d = pc_q;
      end
      SRC_RET: begin
        pc_d  = ras_top & ALIGN_MASK;
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
      SRC_RET_EMPTY: begin
        // Nothing to pop: fall through sequentially and remember the fault.
        pc_d  = pc_next;
        unf_d = 1'b1;
      end
      SRC_JUMP: begin
        pc_d = jump_target_i & ALIGN_MASK;
        if (call_i) begin
          // A full stack overwrites its oldest entry, which is exactly the
          // slot the write pointer has wrapped around to.
          push_en = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          if (!ras_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SRC_BRANCH: begin
        pc_d = branch_target_i & ALIGN_MASK;
      end
      default: begin
        pc_d = pc_next;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage write; no reset since entries are never read while empty.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      ras_q[ptr_q] <= pc_next;
    end
  end

  assign pc_result_o     = pc_q;
  assign pc_next_o       = pc_next;
  assign ras_empty_o     = ras_empty;
  assign ras_full_o      = ras_full;
  assign ras_underflow_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: reset checks, a table
//               of single-cycle vectors, hand-written RAS/stall sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] EXC   = 32'h0000_0080;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, exc = 1'b0, br = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] brt = '0, jt = '0;
  logic [31:0] pc_result, pc_next;
  logic        ras_empty, ras_full, ras_unf;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: PC, stack as a bounded queue, sticky flag.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_unf;

  typedef struct {
    logic        stall, exc, br;
    logic [31:0] brt;
    logic        jmp, call;
    logic [31:0] jt;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_empty, exp_full, exp_unf;
  } vec_t;

  vec_t tbl[20];

  pc_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .exception_i     (exc),
    .branch_taken_i  (br),
    .branch_target_i (brt),
    .jump_i          (jmp),
    .call_i          (call),
    .jump_target_i   (jt),
    .return_i        (ret),
    .pc_result_o     (pc_result),
    .pc_next_o       (pc_next),
    .ras_empty_o     (ras_empty),
    .ras_full_o      (ras_full),
    .ras_underflow_o (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [31:0] pc, input logic empty,
                             input logic full, input logic unf);
    chk({name, ".pc"}, pc_result, pc);
    chk({name, ".pcnext"}, pc_next, pc + 32'h4);
    chk({name, ".empty"}, {31'b0, ras_empty}, {31'b0, empty});
    chk({name, ".full"}, {31'b0, ras_full}, {31'b0, full});
    chk({name, ".unf"}, {31'b0, ras_unf}, {31'b0, unf});
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_unf = 1'b0;
  endtask

  // One clock edge of the architectural behaviour, from the current inputs.
  task automatic model_edge();
    if (exc) begin
      m_pc = EXC;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back() & ~32'h3;
      else begin
        m_pc  = m_pc + 32'h4;
        m_unf = 1'b1;
      end
    end else if (jmp) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'h4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = jt & ~32'h3;
    end else if (br) begin
      m_pc = brt & ~32'h3;
    end else begin
      m_pc = m_pc + 32'h4;
    end
  endtask

  task automatic cmp_model(input string name);
    check_state(name, m_pc, m_ras.size() == 0, m_ras.size() == DEPTH, m_unf);
  endtask

  // Apply one cycle of requests; returns at posedge+1 with inputs idled.
  task automatic drive(input logic s, input logic e, input logic b, input logic [31:0] bt,
                       input logic j, input logic c, input logic [31:0] t, input logic r);
    stall = s; exc = e; br = b; brt = bt; jmp = j; call = c; jt = t; ret = r;
    model_edge();
    @(posedge clk);
    #1;
    stall = 0; exc = 0; br = 0; jmp = 0; call = 0; ret = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    // Table: starts from PC=0 with an empty stack.
    //            st ex br brt           jm ca jt            rt exp_pc        em fu un
    tbl[0]  = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h4,        1, 0, 0};
    tbl[1]  = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h8,        1, 0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'hC,        1, 0, 0};
    tbl[3]  = '{0, 1, 1, 32'h100,     1, 0, 32'h200,      0, 32'h80,       1, 0, 0};
    tbl[4]  = '{0, 0, 1, 32'h100,     1, 0, 32'h200,      0, 32'h200,      1, 0, 0};
    tbl[5]  = '{1, 0, 1, 32'h100,     1, 0, 32'h200,      0, 32'h200,      1, 0, 0};
    tbl[6]  = '{0, 0, 0, 32'h0,       1, 1, 32'h300,      0, 32'h300,      0, 0, 0};
    tbl[7]  = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h204,      1, 0, 0};
    tbl[8]  = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h208,      1, 0, 1};
    tbl[9]  = '{0, 0, 0, 32'h0,       1, 0, 32'h203,      0, 32'h200,      1, 0, 1};
    tbl[10] = '{0, 0, 0, 32'h0,       1, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,        1, 0, 1};
    tbl[12] = '{0, 0, 0, 32'h0,       0, 1, 32'h700,      0, 32'h4,        1, 0, 1};
    tbl[13] = '{1, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h4,        1, 0, 1};
    tbl[14] = '{1, 1, 0, 32'h0,       0, 0, 32'h0,        0, 32'h80,       1, 0, 1};
    tbl[15] = '{0, 0, 0, 32'h0,       1, 1, 32'h600,      1, 32'h84,       1, 0, 1};
    tbl[16] = '{0, 0, 0, 32'h0,       1, 1, 32'h500,      0, 32'h500,      0, 0, 1};
    tbl[17] = '{0, 0, 1, 32'h106,     0, 1, 32'h0,        0, 32'h104,      0, 0, 1};
    tbl[18] = '{0, 1, 0, 32'h0,       0, 0, 32'h0,        1, 32'h80,       0, 0, 1};
    tbl[19] = '{0, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h88,       1, 0, 1};

    // Reset state, held across edges.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle, then sequential stepping.
    drive(0, 0, 0, 0, 1, 0, 32'h1234, 0);
    chk("pre_async.pc", pc_result, 32'h1234);
    rst = 1'b1;
    #1;
    chk("async_reset.pc", pc_result, 32'h0);
    #1;
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq1.pc", pc_result, 32'h4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq2.pc", pc_result, 32'h8);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq3.pc", pc_result, 32'hC);
    chk("seq3.pcnext", pc_next, 32'h10);

    // Table-driven single-cycle vectors.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].stall, tbl[i].exc, tbl[i].br, tbl[i].brt, tbl[i].jmp, tbl[i].call,
            tbl[i].jt, tbl[i].ret);
      check_state($sformatf("tbl%0d", i), tbl[i].exp_pc, tbl[i].exp_empty,
                  tbl[i].exp_full, tbl[i].exp_unf);
    end

    // RAS overflow and underflow.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 1, 1, 32'h10 * (k + 1), 0);
      check_state($sformatf("call%0d", k), 32'h10 * (k + 1), 1'b0, k >= 4, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      check_state($sformatf("ret%0d", k), 32'h54 - 32'h10 * k, k == 3, 1'b0, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check_state("ret_under", 32'h28, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_state("unf_sticky", 32'h2C, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_state("unf_clear", 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    model_reset();

    // Stall with pending Return on an empty stack, then Exception under Stall.
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    check_state("stall_ret1", 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    check_state("stall_ret2", 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    check_state("stall_exc", 32'h80, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] rb, rj;
      rb = $urandom();
      rj = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      if (n % 400 == 399) begin
        do_reset();
      end
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
            rb, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, rj,
            $urandom_range(0, 3) == 0);
      cmp_model($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
